// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing the vertex data memory primary port between the
// vertex core (0), host loader (1) and output drain (2), with lockable bursts.
module dmem_access_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 128,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [2:0]    req_we,
    input  logic [2:0]    req_lock,
    input  logic [3*AW-1:0] req_addr,
    input  logic [3*DW-1:0] req_wdata,
    output logic [2:0]    gnt,
    output logic [2:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        OWN_0    = 2'd0,
        OWN_1    = 2'd1,
        OWN_2    = 2'd2,
        OWN_NONE = 2'd3
    } owner_t;

    owner_t        owner;
    logic [1:0]    rr_ptr;
    logic [CW-1:0] burst_cnt;
    logic [1:0]    own_idx;
    logic [1:0]    gidx;
    logic [1:0]    scan;
    logic          found;
    logic          owner_hold;
    logic          any_gnt;
    logic [CW-1:0] cnt_cur;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;

    function automatic logic [1:0] add_mod3(input logic [1:0] p, input int unsigned k);
        logic [2:0] s;
        s = {1'b0, p} + 3'(k);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    assign own_idx = owner;

    // An owner that drops its request hands the scan start to the requester after it.
    always_comb begin
        gnt        = '0;
        gidx       = 2'd0;
        found      = 1'b0;
        owner_hold = 1'b0;
        scan       = rr_ptr;
        if (!rst) begin
            if (owner != OWN_NONE) begin
                if (req[own_idx]) begin
                    owner_hold = 1'b1;
                    found      = 1'b1;
                    gidx       = own_idx;
                end else begin
                    scan = add_mod3(own_idx, 1);
                end
            end
            for (int unsigned k = 0; k < 3; k++) begin
                if (!found && req[add_mod3(scan, k)]) begin
                    found = 1'b1;
                    gidx  = add_mod3(scan, k);
                end
            end
            if (found) gnt[gidx] = 1'b1;
        end
    end

    assign any_gnt   = |gnt;
    assign mem_we    = |(gnt & req_we);
    assign mem_addr  = any_gnt ? req_addr[gidx*AW +: AW]  : last_addr;
    assign mem_wdata = any_gnt ? req_wdata[gidx*DW +: DW] : last_wdata;
    assign busy      = (owner != OWN_NONE);
    assign cnt_cur   = owner_hold ? burst_cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 2'd0;
            owner      <= OWN_NONE;
            burst_cnt  <= '0;
            rvalid     <= '0;
            rdata      <= '0;
            last_addr  <= '0;
            last_wdata <= '0;
        end else begin
            rvalid <= gnt & ~req_we;
            if (any_gnt) begin
                last_addr  <= mem_addr;
                last_wdata <= mem_wdata;
                if (!req_we[gidx]) rdata <= mem_rdata;
                if (req_lock[gidx] && cnt_cur < BURST_LAST) begin
                    owner     <= owner_t'(gidx);
                    burst_cnt <= cnt_cur + 1'b1;
                end else begin
                    owner     <= OWN_NONE;
                    burst_cnt <= '0;
                    rr_ptr    <= add_mod3(gidx, 1);
                end
            end else if (owner != OWN_NONE) begin
                owner     <= OWN_NONE;
                burst_cnt <= '0;
                rr_ptr    <= add_mod3(own_idx, 1);
            end
        end
    end
endmodule
